// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and defaults for the pipeline sequencer.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;
  localparam int CNT_W_DEF = 16;
  typedef struct packed {
    logic en;
    logic bubble;
  } stage_ctrl_t;
endpackage

// File: rtl/pipe_ctrl_load_use.sv
// load_use_detect: flags a load in DX whose destination feeds a source read in FD.
module load_use_detect (
  input  logic       DX_memRead,
  input  logic [2:0] DX_writeReg,
  input  logic [2:0] FD_rs,
  input  logic [2:0] FD_rt,
  input  logic       FD_rs_used,
  input  logic       FD_rt_used,
  output logic       load_use
);
  assign load_use = DX_memRead & ((FD_rs_used & (FD_rs == DX_writeReg)) |
                                  (FD_rt_used & (FD_rt == DX_writeReg)));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-cycle enable/bubble sequencer for the five-stage pipeline.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_done,
  input  logic             dmem_req,
  input  logic             dmem_done,
  input  logic             DX_memRead,
  input  logic [2:0]       DX_writeReg,
  input  logic [2:0]       FD_rs,
  input  logic [2:0]       FD_rt,
  input  logic             FD_rs_used,
  input  logic             FD_rt_used,
  input  logic             XM_redirect,
  input  logic             FD_halt,
  input  logic             MW_halt,
  output logic             pc_en,
  output logic             FD_en,
  output logic             DX_en,
  output logic             XM_en,
  output logic             MW_en,
  output logic             FD_bubble,
  output logic             DX_bubble,
  output logic             XM_bubble,
  output logic             MW_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t            state_q, state_d;
  logic              drain_q, drain_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  stage_ctrl_t       fd, dx, xm, mw;
  logic              load_use, mode_drain, mem_wait;

  load_use_detect u_lud (
    .DX_memRead (DX_memRead),
    .DX_writeReg(DX_writeReg),
    .FD_rs      (FD_rs),
    .FD_rt      (FD_rt),
    .FD_rs_used (FD_rs_used),
    .FD_rt_used (FD_rt_used),
    .load_use   (load_use)
  );

  // DWAIT resumes into whichever mode it interrupted, tracked by drain_q.
  always_comb begin
    fd = '{en: 1'b1, bubble: 1'b0};
    dx = '{en: 1'b1, bubble: 1'b0};
    xm = '{en: 1'b1, bubble: 1'b0};
    mw = '{en: 1'b1, bubble: 1'b0};
    pc_en = 1'b1;
    halted = 1'b0;
    state_d = state_q;
    drain_d = drain_q;
    mode_drain = (state_q == DRAIN) | ((state_q == DWAIT) & drain_q);
    mem_wait = (state_q == DWAIT) ? ~dmem_done : dmem_req & ~dmem_done;
    if (state_q == HALTED) begin
      pc_en = 1'b0;
      fd.en = 1'b0;
      dx.en = 1'b0;
      xm.en = 1'b0;
      mw.en = 1'b0;
      halted = 1'b1;
    end else if (mem_wait) begin
      pc_en = 1'b0;
      fd.en = 1'b0;
      dx.en = 1'b0;
      xm.en = 1'b0;
      mw.bubble = 1'b1;
      state_d = DWAIT;
      drain_d = mode_drain;
    end else begin
      state_d = mode_drain ? (MW_halt ? HALTED : DRAIN) : RUN;
      if (mode_drain) begin
        pc_en = 1'b0;
        fd.bubble = 1'b1;
        dx.bubble = XM_redirect;
        xm.bubble = XM_redirect;
      end else if (XM_redirect) begin
        fd.bubble = 1'b1;
        dx.bubble = 1'b1;
        xm.bubble = 1'b1;
      end else if (load_use) begin
        pc_en = 1'b0;
        fd.en = 1'b0;
        dx.bubble = 1'b1;
      end else if (!imem_done) begin
        pc_en = 1'b0;
        fd.bubble = 1'b1;
      end else if (FD_halt) begin
        pc_en = 1'b0;
        state_d = DRAIN;
      end
    end
  end

  assign stall_cnt_d = (!pc_en && state_q != HALTED && !(&stall_cnt_q)) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign {FD_en, FD_bubble} = fd;
  assign {DX_en, DX_bubble} = dx;
  assign {XM_en, XM_bubble} = xm;
  assign {MW_en, MW_bubble} = mw;
  assign stall_cnt = stall_cnt_q;
endmodule
